clock_div_multi: RTL and testbench

//   Multi-channel programmable clock divider / tick generator. Each channel

---
 rtl/clock_div_multi.sv | 112 +++++++++++
 tb/tb_clock_div_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider: per-channel tick and square wave with
// glitch-free shadowed divisor reload, plus a scan counter stepped by channel 0.
module clock_div_multi #(
    parameter int unsigned          NCH     = 2,
    parameter int unsigned          CNT_W   = 32,
    parameter int unsigned          SEL_W   = 1,
    parameter int unsigned          SCAN_W  = 2,
    parameter logic [NCH*CNT_W-1:0] DEF_DIV = {32'd14, 32'd49_999}
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              restart,
    input  logic [NCH-1:0]    en,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NCH-1:0]    cfg_pend,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    wave,
    output logic [SCAN_W-1:0] s
);

    logic [CNT_W-1:0]  cnt_q    [NCH];
    logic [CNT_W-1:0]  cnt_d    [NCH];
    logic [CNT_W-1:0]  active_q [NCH];
    logic [CNT_W-1:0]  active_d [NCH];
    logic [CNT_W-1:0]  shadow_q [NCH];
    logic [CNT_W-1:0]  shadow_d [NCH];
    logic [NCH-1:0]    pend_q, pend_d;
    logic [NCH-1:0]    tick_q, tick_d;
    logic [NCH-1:0]    wave_q, wave_d;
    logic [NCH-1:0]    wr_hit;
    logic [SCAN_W-1:0] s_q, s_d;

    // An out-of-range cfg_sel matches no channel, so the write is dropped.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg_we && (32'(cfg_sel) == i);
        end
    end

    always_comb begin
        pend_d = pend_q;
        tick_d = '0;
        wave_d = wave_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            active_d[i] = active_q[i];
            shadow_d[i] = wr_hit[i] ? cfg_div : shadow_q[i];
            pend_d[i]   = pend_q[i] | wr_hit[i];
            if (restart) begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end else if (en[i]) begin
                if (cnt_q[i] == active_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    wave_d[i] = ~wave_q[i];
                    // A write landing on TC stays pending; active takes the older shadow.
                    if (pend_q[i]) begin
                        active_d[i] = shadow_q[i];
                        pend_d[i]   = wr_hit[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (pend_q[i]) begin
                active_d[i] = shadow_q[i];
                cnt_d[i]    = '0;
                pend_d[i]   = wr_hit[i];
            end
        end
        if (restart) begin
            s_d = '0;
        end else if (tick_d[0]) begin
            s_d = s_q + 1'b1;
        end else begin
            s_d = s_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                active_q[i] <= DEF_DIV[i*CNT_W +: CNT_W];
                shadow_q[i] <= DEF_DIV[i*CNT_W +: CNT_W];
            end
            pend_q <= '0;
            tick_q <= '0;
            wave_q <= '0;
            s_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pend_q <= pend_d;
            tick_q <= tick_d;
            wave_q <= wave_d;
            s_q    <= s_d;
        end
    end

    assign cfg_pend = pend_q;
    assign tick     = tick_q;
    assign wave     = wave_q;
    assign s        = s_q;

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: reset tick table plus hand-built
// sequences for reload, TC-write, gating, bad select, restart and async clear.
module tb_clock_div_multi;

    logic       clk;
    logic       clr_n;
    logic       restart;
    logic [1:0] en;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_div;
    logic [1:0] cfg_pend;
    logic [1:0] tick;
    logic [1:0] wave;
    logic [1:0] s;

    int checks   = 0;
    int failures = 0;

    clock_div_multi #(
        .NCH    (2),
        .CNT_W  (8),
        .SEL_W  (2),
        .SCAN_W (2),
        .DEF_DIV({8'd1, 8'd4})
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .restart (restart),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_div (cfg_div),
        .cfg_pend(cfg_pend),
        .tick    (tick),
        .wave    (wave),
        .s       (s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] en;
        logic [1:0] exp_tick;
        logic [1:0] exp_wave;
        logic [1:0] exp_s;
        logic [1:0] exp_pend;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic [1:0] e, logic [1:0] t, logic [1:0] w,
                                logic [1:0] sv, logic [1:0] p);
        vec_t v;
        v.en = e; v.exp_tick = t; v.exp_wave = w; v.exp_s = sv; v.exp_pend = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < maxc);
        if (!tick[ch]) n = maxc + 1;
    endtask

    task automatic write_cfg(input logic [1:0] sel, input logic [7:0] div);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_div = div;
        step();
        cfg_we  = 1'b0;
        cfg_sel = 2'd0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    int n;

    initial begin
        // ch0 divisor 4 from reset: ticks after edges 5,10,15,20
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'd0, 2'b00);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'd0, 2'b00);
        tbl[2]  = mk(2'b01, 2'b00, 2'b00, 2'd0, 2'b00);
        tbl[3]  = mk(2'b01, 2'b00, 2'b00, 2'd0, 2'b00);
        tbl[4]  = mk(2'b01, 2'b01, 2'b01, 2'd1, 2'b00);
        tbl[5]  = mk(2'b01, 2'b00, 2'b01, 2'd1, 2'b00);
        tbl[6]  = mk(2'b01, 2'b00, 2'b01, 2'd1, 2'b00);
        tbl[7]  = mk(2'b01, 2'b00, 2'b01, 2'd1, 2'b00);
        tbl[8]  = mk(2'b01, 2'b00, 2'b01, 2'd1, 2'b00);
        tbl[9]  = mk(2'b01, 2'b01, 2'b00, 2'd2, 2'b00);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 2'd2, 2'b00);
        tbl[11] = mk(2'b01, 2'b00, 2'b00, 2'd2, 2'b00);
        tbl[12] = mk(2'b01, 2'b00, 2'b00, 2'd2, 2'b00);
        tbl[13] = mk(2'b01, 2'b00, 2'b00, 2'd2, 2'b00);
        tbl[14] = mk(2'b01, 2'b01, 2'b01, 2'd3, 2'b00);
        tbl[15] = mk(2'b01, 2'b00, 2'b01, 2'd3, 2'b00);
        tbl[16] = mk(2'b01, 2'b00, 2'b01, 2'd3, 2'b00);
        tbl[17] = mk(2'b01, 2'b00, 2'b01, 2'd3, 2'b00);
        tbl[18] = mk(2'b01, 2'b00, 2'b01, 2'd3, 2'b00);
        tbl[19] = mk(2'b01, 2'b01, 2'b00, 2'd0, 2'b00);

        clr_n = 1'b0; restart = 1'b0; en = 2'b01;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_div = 8'd0;
        #11;
        chk("rst_tick", tick, 2'b00);
        chk("rst_wave", wave, 2'b00);
        chk("rst_s", s, 2'd0);
        chk("rst_pend", cfg_pend, 2'b00);
        #1 clr_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en;
            step();
            chk($sformatf("t1_tick[%0d]", i + 1), tick, tbl[i].exp_tick);
            chk($sformatf("t1_wave[%0d]", i + 1), wave, tbl[i].exp_wave);
            chk($sformatf("t1_s[%0d]", i + 1), s, tbl[i].exp_s);
            chk($sformatf("t1_pend[%0d]", i + 1), cfg_pend, tbl[i].exp_pend);
        end

        // Live reload: div 9, write 3 mid-period
        en = 2'b00;
        write_cfg(2'd0, 8'd9);
        chk("t2_idle_pend_set", cfg_pend, 2'b01);
        step();
        chk("t2_idle_pend_clr", cfg_pend, 2'b00);
        do_restart();
        chk("t2_rst_s", s, 2'd0);
        en = 2'b01;
        step(); step();
        write_cfg(2'd0, 8'd3);
        chk("t2_pend_live", cfg_pend, 2'b01);
        wait_tick(0, 40, n);
        chk("t2_first_period_rest", n, 7);
        chk("t2_pend_after_tc", cfg_pend, 2'b00);
        wait_tick(0, 40, n);
        chk("t2_new_period_a", n, 4);
        wait_tick(0, 40, n);
        chk("t2_new_period_b", n, 4);
        chk("t2_wave", wave, 2'b01);
        chk("t2_s", s, 2'd3);

        // Write on the TC cycle: pending 5 applies, 2 stays pending
        en = 2'b00;
        write_cfg(2'd0, 8'd5);
        step();
        do_restart();
        en = 2'b01;
        step(); step();
        write_cfg(2'd0, 8'd5);
        chk("t3_pend_pre", cfg_pend, 2'b01);
        step(); step();
        write_cfg(2'd0, 8'd2);
        chk("t3_tick_on_tc", tick, 2'b01);
        chk("t3_pend_kept", cfg_pend, 2'b01);
        wait_tick(0, 40, n);
        chk("t3_period_old", n, 6);
        chk("t3_pend_clr", cfg_pend, 2'b00);
        wait_tick(0, 40, n);
        chk("t3_period_new", n, 3);

        // en gating holds the count on ch0 (div 2)
        step(); step();
        en = 2'b00;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t4_gated_tick0[%0d]", i), tick[0], 1'b0);
        end
        en = 2'b01;
        wait_tick(0, 40, n);
        chk("t4_resume_phase", n, 1);

        // div 0 on ch1: tick always high, wave at clk/2, gating holds wave
        en = 2'b00;
        write_cfg(2'd1, 8'd0);
        chk("t4_ch1_pend_set", cfg_pend, 2'b10);
        step();
        chk("t4_ch1_pend_clr", cfg_pend, 2'b00);
        do_restart();
        en = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_div0_tick[%0d]", i), tick[1], 1'b1);
            chk($sformatf("t4_div0_wave[%0d]", i), wave[1], (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        en = 2'b00;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t4_hold_tick1[%0d]", i), tick[1], 1'b0);
            chk($sformatf("t4_hold_wave1[%0d]", i), wave[1], 1'b1);
        end
        en = 2'b10;
        step();
        chk("t4_resume_tick1", tick[1], 1'b1);
        chk("t4_resume_wave1", wave[1], 1'b0);

        // Disabled reload takes effect at once; out-of-range select is ignored
        en = 2'b00;
        write_cfg(2'd0, 8'd7);
        chk("t5_pend_set", cfg_pend, 2'b01);
        step();
        chk("t5_pend_applied", cfg_pend, 2'b00);
        en = 2'b01;
        wait_tick(0, 40, n);
        chk("t5_period7", n, 8);
        en = 2'b00;
        write_cfg(2'd3, 8'd1);
        chk("t5_badsel_pend", cfg_pend, 2'b00);
        chk("t5_badsel_tick", tick, 2'b00);
        chk("t5_badsel_wave", wave, 2'b01);
        chk("t5_badsel_s", s, 2'd1);
        step();
        chk("t5_badsel_pend2", cfg_pend, 2'b00);
        en = 2'b01;
        wait_tick(0, 40, n);
        chk("t5_badsel_period", n, 8);

        // restart mid-period keeps divisor; async clear restores defaults
        wait_tick(0, 40, n);
        chk("t6_pre_period", n, 8);
        step(); step(); step();
        do_restart();
        chk("t6_rs_tick", tick, 2'b00);
        chk("t6_rs_wave", wave, 2'b00);
        chk("t6_rs_s", s, 2'd0);
        wait_tick(0, 40, n);
        chk("t6_rs_period", n, 8);
        chk("t6_rs_pend", cfg_pend, 2'b00);
        write_cfg(2'd0, 8'd9);
        step();
        chk("t6_pre_clr_pend", cfg_pend, 2'b01);
        chk("t6_pre_clr_wave", wave, 2'b01);
        chk("t6_pre_clr_s", s, 2'd1);
        #3 clr_n = 1'b0;
        #1;
        chk("t6_clr_tick", tick, 2'b00);
        chk("t6_clr_wave", wave, 2'b00);
        chk("t6_clr_s", s, 2'd0);
        chk("t6_clr_pend", cfg_pend, 2'b00);
        #1 clr_n = 1'b1;
        wait_tick(0, 40, n);
        chk("t6_def_period", n, 5);
        chk("t6_def_s", s, 2'd1);
        chk("t6_def_wave", wave, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
